// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
// Module  : syscall_unit
// Brief   : Executes exit/print/pause syscalls, drives CPU halt, and scans the
//           last printed value onto an 8-digit seven-segment display.
// Rev     : 1.0  initial release
// ============================================================================
module syscall_unit #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter logic [31:0] SVC_PRINT_INT = 32'd1,
  parameter logic [31:0] SVC_EXIT      = 32'd10,
  parameter logic [31:0] SVC_PRINT_HEX = 32'd34,
  parameter logic [31:0] SVC_PAUSE     = 32'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic        go,
  output logic        halt,
  output logic [31:0] disp_data,
  output logic [31:0] syscall_count,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int unsigned c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_refresh_max = c_cnt_w'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_halt;
  logic                r_go_prev;
  logic [31:0]         r_disp;
  logic [31:0]         r_count;
  logic [c_cnt_w-1:0]  r_refresh;
  logic [2:0]          r_digit;
  logic                w_accept;
  logic                w_go_rise;
  logic                w_print;
  logic [3:0]          w_nibble;

  assign w_accept  = syscall && (r_state == ST_RUN);
  assign w_go_rise = go && !r_go_prev;
  assign w_print   = w_accept && ((v0 == SVC_PRINT_INT) || (v0 == SVC_PRINT_HEX));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if (v0 == SVC_EXIT)       w_state_next = ST_HALT;
          else if (v0 == SVC_PAUSE) w_state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: if (w_go_rise) w_state_next = ST_RUN;
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // halt is registered alongside the state so it tracks state != RUN exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_halt    <= 1'b0;
      r_go_prev <= 1'b0;
      r_disp    <= 32'd0;
      r_count   <= 32'd0;
      r_refresh <= '0;
      r_digit   <= 3'd0;
    end else begin
      r_state   <= w_state_next;
      r_halt    <= (w_state_next != ST_RUN);
      r_go_prev <= go;
      if (w_accept) r_count <= r_count + 32'd1;
      if (w_print)  r_disp  <= a0;
      if (r_refresh == c_refresh_max) begin
        r_refresh <= '0;
        r_digit   <= r_digit + 3'd1;
      end else begin
        r_refresh <= r_refresh + c_cnt_w'(1);
      end
    end
  end

  assign w_nibble = r_disp[{r_digit, 2'b00} +: 4];

  always_comb begin
    seg = 8'hFF;
    case (w_nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

  assign an            = ~(8'b0000_0001 << r_digit);
  assign halt          = r_halt;
  assign disp_data     = r_disp;
  assign syscall_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_syscall_unit
// Brief   : Directed plus randomized checks of syscall_unit against a
//           cycle-level behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_syscall_unit;

  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst, syscall, go;
  logic [31:0] v0, a0;
  logic        halt;
  logic [31:0] disp_data, syscall_count;
  logic [7:0]  seg, an;

  int total = 0;
  int bad   = 0;

  syscall_unit #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0), .go(go),
    .halt(halt), .disp_data(disp_data), .syscall_count(syscall_count),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=running, 1=paused, 2=halted; display digit from elapsed cycles
  int              m_state = 0;
  logic [31:0]     m_count = 0;
  logic [31:0]     m_disp  = 0;
  logic            m_gprev = 0;
  longint unsigned m_t     = 0;
  bit              m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_count = 0; m_disp = 0; m_gprev = 0; m_t = 0; m_valid = 1;
    end else begin
      if (m_state == 0 && syscall) begin
        m_count = m_count + 1;
        if (v0 == 32'd10)                      m_state = 2;
        else if (v0 == 32'd50)                 m_state = 1;
        else if (v0 == 32'd1 || v0 == 32'd34)  m_disp  = a0;
      end else if (m_state == 1 && go && !m_gprev) begin
        m_state = 0;
      end
      m_gprev = go;
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int d;
      d = int'((m_t / DIV) % 8);
      chk("m_halt",  {31'd0, halt}, {31'd0, m_state != 0});
      chk("m_disp",  disp_data, m_disp);
      chk("m_count", syscall_count, m_count);
      chk("m_an",    {24'd0, an},  {24'd0, ~(8'd1 << d)});
      chk("m_seg",   {24'd0, seg}, {24'd0, seg_tab[m_disp[d*4 +: 4]]});
    end
  end

  // Called just after a falling edge; returns at the falling edge after the syscall edge
  task automatic sys(input logic [31:0] code, input logic [31:0] val);
    syscall = 1'b1; v0 = code; a0 = val;
    @(negedge clk);
    syscall = 1'b0; v0 = $urandom; a0 = $urandom;
  endtask

  initial begin
    int n;
    rst = 1'b1; syscall = 1'b0; go = 1'b0; v0 = 32'd0; a0 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_an",    {24'd0, an},  32'hFE);
    chk("rst_seg",   {24'd0, seg}, 32'hC0);
    chk("rst_halt",  {31'd0, halt}, 32'd0);
    chk("rst_count", syscall_count, 32'd0);
    chk("rst_disp",  disp_data, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_halt",  {31'd0, halt}, 32'd0);
    chk("idle_count", syscall_count, 32'd0);
    chk("idle_seg",   {24'd0, seg}, 32'hC0);

    // print hex
    sys(32'd34, 32'h1234ABCD);
    chk("prt_disp",  disp_data, 32'h1234ABCD);
    chk("prt_count", syscall_count, 32'd1);
    chk("prt_halt",  {31'd0, halt}, 32'd0);
    n = 0;
    while (an == 8'hFE && n < 40) begin @(negedge clk); n++; end
    while (an != 8'hFE && n < 40) begin @(negedge clk); n++; end
    chk("scan_sync", {31'd0, n < 40}, 32'd1);
    chk("scan_d0_seg", {24'd0, seg}, 32'hA1);
    repeat (2) @(negedge clk);
    chk("scan_d1_an",  {24'd0, an},  32'hFD);
    chk("scan_d1_seg", {24'd0, seg}, 32'hC6);

    // pause with go already held high
    go = 1'b1;
    @(negedge clk);
    sys(32'd50, 32'd0);
    chk("pause_halt", {31'd0, halt}, 32'd1);
    sys(32'd34, 32'hDEADBEEF);
    chk("pause_disp",  disp_data, 32'h1234ABCD);
    chk("pause_count", syscall_count, 32'd2);
    repeat (3) @(negedge clk);
    chk("pause_held_go", {31'd0, halt}, 32'd1);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    repeat (2) @(negedge clk);
    chk("pause_resume", {31'd0, halt}, 32'd0);
    go = 1'b0;
    @(negedge clk);

    // exit, then only reset recovers
    sys(32'd10, 32'd0);
    chk("exit_halt", {31'd0, halt}, 32'd1);
    go = 1'b1; @(negedge clk); go = 1'b0;
    sys(32'd1, 32'd5);
    sys(32'd34, 32'd6);
    chk("exit_stuck",  {31'd0, halt}, 32'd1);
    chk("exit_count",  syscall_count, 32'd3);
    chk("exit_disp",   disp_data, 32'h1234ABCD);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("exit_rst_halt",  {31'd0, halt}, 32'd0);
    chk("exit_rst_count", syscall_count, 32'd0);
    chk("exit_rst_disp",  disp_data, 32'd0);

    // unknown codes count only; v0 compared on all 32 bits
    sys(32'd7, 32'h0000AAAA);
    chk("unk_count", syscall_count, 32'd1);
    chk("unk_disp",  disp_data, 32'd0);
    chk("unk_halt",  {31'd0, halt}, 32'd0);
    sys(32'h00000122, 32'h00005555);
    chk("wide_count", syscall_count, 32'd2);
    chk("wide_disp",  disp_data, 32'd0);
    sys(32'd1, 32'hCAFEF00D);
    chk("int_disp",  disp_data, 32'hCAFEF00D);
    chk("int_count", syscall_count, 32'd3);

    // reset wins over a same-cycle print
    rst = 1'b1; syscall = 1'b1; v0 = 32'd34; a0 = 32'h11111111;
    @(negedge clk);
    rst = 1'b0; syscall = 1'b0;
    chk("rstpri_disp",  disp_data, 32'd0);
    chk("rstpri_count", syscall_count, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 119) == 0);
      syscall = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       v0 = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'd34;
        1, 2:    v0 = 32'd50;
        3, 4:    v0 = 32'd34;
        5:       v0 = 32'd1;
        6:       v0 = 32'd7;
        7:       v0 = $urandom;
        8:       v0 = 32'd35;
        default: v0 = 32'd33;
      endcase
      a0 = $urandom;
      if ($urandom_range(0, 2) == 0) go = ~go;
      @(negedge clk);
    end
    rst = 1'b0; syscall = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
